// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   SEG_*        : 7-bit glyphs, bit order {g,f,e,d,c,b,a}, active-high
//   blink_phase_e: visible/hidden phase of the whole-display blink
//   bcd_to_seg() : 4-bit code to glyph; codes 10-15 render as a dash
package ssd_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic {PhVisible, PhHidden} blink_phase_e;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ssd_blank_mask.sv
// Leading-zero blank mask for the scan driver.
//   digits_i : packed BCD digits, digit i at [4i+3:4i], digit 0 least significant
//   blank_o  : bit i set when digit i and every more significant digit are zero
// Purely combinational. Non-BCD codes (10-15) count as nonzero.
module ssd_blank_mask #(
  parameter int unsigned N_DIGITS = 3
) (
  input  logic [4*N_DIGITS-1:0] digits_i,
  output logic [N_DIGITS-1:0]   blank_o
);

  logic nz_seen;

  // Walk from the most significant digit down; once a nonzero digit is seen,
  // nothing below it may be blanked.
  always_comb begin
    blank_o = '0;
    nz_seen = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      nz_seen    = nz_seen | (digits_i[4*i +: 4] != 4'd0);
      blank_o[i] = ~nz_seen;
    end
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment driver with frame-aligned double buffering,
// leading-zero blanking and whole-display blink.
//   clk, reset  : clock, synchronous active-high reset
//   load        : one-cycle strobe capturing digits_in into the pending buffer
//   digits_in   : packed BCD, digit i at [4i+3:4i]
//   blank_en    : enable leading-zero blanking
//   blink_en    : enable blinking (BLINK_FRAMES frames per half-period)
//   seg         : registered segments {g,f,e,d,c,b,a}
//   an          : registered one-hot digit enable
//   frame_done  : one-cycle pulse following each frame wrap
// ACTIVE_LOW inverts seg and an at the pins only.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 3,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic                  blank_en,
  input  logic                  blink_en,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int unsigned IdxW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned PresW  = $clog2(SCAN_DIV);
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(N_DIGITS - 1);
  localparam logic [PresW-1:0]  PresLast  = PresW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);

  logic [PresW-1:0]      presc_q, presc_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [4*N_DIGITS-1:0] pending_q, pending_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [4*N_DIGITS-1:0] active_q, active_d;
  logic [BlinkW-1:0]     blink_cnt_q, blink_cnt_d;
  blink_phase_e          phase_q, phase_d;
  logic [6:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic                  presc_wrap;
  logic                  frame_wrap;
  logic                  hide;
  logic [3:0]            cur_digit;
  logic [N_DIGITS-1:0]   blank_mask;

  ssd_blank_mask #(
    .N_DIGITS(N_DIGITS)
  ) u_blank_mask (
    .digits_i(active_q),
    .blank_o (blank_mask)
  );

  assign presc_wrap = (presc_q == PresLast);
  assign frame_wrap = presc_wrap && (idx_q == IdxLast);
  assign cur_digit  = active_q[4*int'(idx_q) +: 4];
  // Gate with blink_en directly so dropping it un-hides on the very next cycle.
  assign hide       = blink_en && (phase_q == PhHidden);

  always_comb begin
    // Scan timing
    presc_d = presc_wrap ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_wrap) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end

    // Double buffer: a load coinciding with the wrap bypasses pending.
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    active_d     = active_q;
    if (frame_wrap) begin
      pend_valid_d = 1'b0;
      if (load) begin
        active_d = digits_in;
      end else if (pend_valid_q) begin
        active_d = pending_q;
      end
    end else if (load) begin
      pending_d    = digits_in;
      pend_valid_d = 1'b1;
    end

    // Blink phase
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!blink_en) begin
      blink_cnt_d = '0;
      phase_d     = PhVisible;
    end else if (frame_wrap) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d = '0;
        phase_d     = (phase_q == PhVisible) ? PhHidden : PhVisible;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // Output stage, one cycle behind the scan index
    an_d = hide ? '0 : (N_DIGITS'(1) << idx_q);
    if (hide || (blank_en && blank_mask[idx_q])) begin
      seg_d = SEG_OFF;
    end else begin
      seg_d = bcd_to_seg(cur_digit);
    end
    frame_done_d = frame_wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
      active_q     <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= PhVisible;
      seg_q        <= SEG_OFF;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      active_q     <= active_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = ACTIVE_LOW ? ~seg_q : seg_q;
  assign an         = ACTIVE_LOW ? ~an_q : an_q;
  assign frame_done = frame_done_q;

endmodule
